// File: rtl/ir_packet_scheduler.sv
// rtl/ir_packet_scheduler.sv - periodic IR packet trigger, command arbitration and TX handshake
module ir_packet_scheduler #(
  parameter int unsigned PERIOD_CYCLES  = 10000000,
  parameter int unsigned BUS_HOLD_TICKS = 20,
  parameter int unsigned START_TIMEOUT  = 16
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       ENABLE,
  input  logic [3:0] SW_COMMAND,
  input  logic [3:0] BUS_COMMAND,
  input  logic       BUS_WE,
  input  logic       TX_IDLE,
  output logic [3:0] COMMAND,
  output logic       SEND_PACKET,
  output logic       BUSY,
  output logic       SOURCE,
  output logic [7:0] PACKET_COUNT,
  output logic [7:0] OVERRUN_COUNT,
  output logic       ERROR
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_START,
    ST_WAIT_DONE
  } state_t;

  localparam logic [23:0] PERIOD_LAST  = 24'(PERIOD_CYCLES - 1);
  localparam logic [7:0]  HOLD_LOAD    = 8'(BUS_HOLD_TICKS);
  localparam logic [4:0]  TIMEOUT_LAST = 5'(START_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [23:0] period_q, period_d;
  logic [7:0]  hold_q, hold_d;
  logic [3:0]  bus_cmd_q, bus_cmd_d;
  logic [4:0]  timeout_q, timeout_d;
  logic [3:0]  command_q, command_d;
  logic        send_q, send_d;
  logic        busy_q, busy_d;
  logic        source_q, source_d;
  logic [7:0]  pkt_q, pkt_d;
  logic [7:0]  ovr_q, ovr_d;
  logic        error_q, error_d;

  logic       tick;
  logic       sel_bus;
  logic [3:0] sel_cmd;

  // A same-cycle bus write wins over the stored bus command and counts as an active hold.
  assign tick    = ENABLE && (period_q == PERIOD_LAST);
  assign sel_bus = BUS_WE || (hold_q != 8'd0);
  assign sel_cmd = BUS_WE ? BUS_COMMAND : (sel_bus ? bus_cmd_q : SW_COMMAND);

  // Next-state logic: period counter, bus hold, handshake FSM and status counters.
  always_comb begin
    state_d   = state_q;
    period_d  = (!ENABLE || tick) ? 24'd0 : period_q + 24'd1;
    hold_d    = hold_q;
    bus_cmd_d = bus_cmd_q;
    timeout_d = timeout_q;
    command_d = command_q;
    send_d    = 1'b0;
    source_d  = source_q;
    pkt_d     = pkt_q;
    ovr_d     = ovr_q;
    error_d   = error_q;

    if (BUS_WE) begin
      bus_cmd_d = BUS_COMMAND;
      hold_d    = HOLD_LOAD;
    end else if (tick && (hold_q != 8'd0)) begin
      hold_d = hold_q - 8'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          command_d = sel_cmd;
          source_d  = sel_bus;
          send_d    = 1'b1;
          pkt_d     = pkt_q + 8'd1;
          timeout_d = 5'd0;
          state_d   = ST_WAIT_START;
        end
      end
      ST_WAIT_START: begin
        if (!TX_IDLE) begin
          state_d = ST_WAIT_DONE;
        end else if (timeout_q == TIMEOUT_LAST) begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          timeout_d = timeout_q + 5'd1;
        end
      end
      ST_WAIT_DONE: begin
        if (TX_IDLE) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A tick that arrives while a packet is in flight is dropped and counted.
    if (tick && (state_q != ST_IDLE) && (ovr_q != 8'hFF)) begin
      ovr_d = ovr_q + 8'd1;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs; reset aborts any packet immediately.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= ST_IDLE;
      period_q  <= 24'd0;
      hold_q    <= 8'd0;
      bus_cmd_q <= 4'd0;
      timeout_q <= 5'd0;
      command_q <= 4'd0;
      send_q    <= 1'b0;
      busy_q    <= 1'b0;
      source_q  <= 1'b0;
      pkt_q     <= 8'd0;
      ovr_q     <= 8'd0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      period_q  <= period_d;
      hold_q    <= hold_d;
      bus_cmd_q <= bus_cmd_d;
      timeout_q <= timeout_d;
      command_q <= command_d;
      send_q    <= send_d;
      busy_q    <= busy_d;
      source_q  <= source_d;
      pkt_q     <= pkt_d;
      ovr_q     <= ovr_d;
      error_q   <= error_d;
    end
  end

  assign COMMAND       = command_q;
  assign SEND_PACKET   = send_q;
  assign BUSY          = busy_q;
  assign SOURCE        = source_q;
  assign PACKET_COUNT  = pkt_q;
  assign OVERRUN_COUNT = ovr_q;
  assign ERROR         = error_q;

endmodule

// File: tb/tb_ir_packet_scheduler.sv
// tb/tb_ir_packet_scheduler.sv - randomized self-checking bench for ir_packet_scheduler
module tb_ir_packet_scheduler;

  localparam int P  = 100;
  localparam int H  = 3;
  localparam int TO = 16;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic       ENABLE;
  logic [3:0] SW_COMMAND;
  logic [3:0] BUS_COMMAND;
  logic       BUS_WE;
  logic       TX_IDLE;
  logic [3:0] COMMAND;
  logic       SEND_PACKET;
  logic       BUSY;
  logic       SOURCE;
  logic [7:0] PACKET_COUNT;
  logic [7:0] OVERRUN_COUNT;
  logic       ERROR;

  ir_packet_scheduler #(
    .PERIOD_CYCLES (P),
    .BUS_HOLD_TICKS(H),
    .START_TIMEOUT (TO)
  ) dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .ENABLE       (ENABLE),
    .SW_COMMAND   (SW_COMMAND),
    .BUS_COMMAND  (BUS_COMMAND),
    .BUS_WE       (BUS_WE),
    .TX_IDLE      (TX_IDLE),
    .COMMAND      (COMMAND),
    .SEND_PACKET  (SEND_PACKET),
    .BUSY         (BUSY),
    .SOURCE       (SOURCE),
    .PACKET_COUNT (PACKET_COUNT),
    .OVERRUN_COUNT(OVERRUN_COUNT),
    .ERROR        (ERROR)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: cycle index, tick phase origin, hold budget, busy window end.
  int cyc, en_start, prev_en, hold_left, bus_reg, idle_from, err_at, err_armed;
  int m_cmd, m_src, m_send, m_busy, m_pkt, m_ovr, m_err;
  // TX behaviour: drop TX_IDLE md_d cycles after SEND_PACKET for md_L cycles (md_d < 0: never).
  int md_d = 2, md_L = 50;
  int pk_d, pk_L;
  int tx_send, tx_d, tx_L;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    prev_en = 0; en_start = 0; hold_left = 0; bus_reg = 0;
    idle_from = 0; err_at = 0; err_armed = 0;
    m_cmd = 0; m_src = 0; m_send = 0; m_busy = 0; m_pkt = 0; m_ovr = 0; m_err = 0;
    pk_d = -1; pk_L = 0;
    tx_send = -1000000; tx_d = -1; tx_L = 0;
  endtask

  task automatic step();
    int  c;
    bit  tick, idle;
    c = cyc;
    TX_IDLE = !(tx_d >= 0 && c >= tx_send + tx_d && c < tx_send + tx_d + tx_L);
    if (ENABLE && prev_en == 0) en_start = c;
    prev_en = ENABLE;
    tick = ENABLE && ((c - en_start) % P == P - 1);
    idle = (c >= idle_from);
    m_send = 0;
    if (tick) begin
      if (idle) begin
        m_src  = (BUS_WE || hold_left > 0) ? 1 : 0;
        m_cmd  = BUS_WE ? int'(BUS_COMMAND) : (hold_left > 0 ? bus_reg : int'(SW_COMMAND));
        m_send = 1;
        m_pkt  = (m_pkt + 1) % 256;
        pk_d   = md_d;
        pk_L   = md_L;
        if (md_d < 0) begin
          idle_from = c + TO + 1;
          err_at    = c + TO + 1;
          err_armed = 1;
        end else begin
          idle_from = c + md_d + md_L + 2;
        end
      end else if (m_ovr < 255) begin
        m_ovr++;
      end
    end
    if (BUS_WE) begin
      bus_reg   = BUS_COMMAND;
      hold_left = H;
    end else if (tick && hold_left > 0) begin
      hold_left--;
    end
    m_busy = (c + 1 < idle_from) ? 1 : 0;
    if (err_armed != 0 && c + 1 >= err_at) m_err = 1;

    @(posedge CLK);
    #1;
    cyc++;
    BUS_WE = 1'b0;
    check("command", COMMAND, m_cmd);
    check("send", SEND_PACKET, m_send);
    check("busy", BUSY, m_busy);
    check("source", SOURCE, m_src);
    check("pkt_count", PACKET_COUNT, m_pkt);
    check("ovr_count", OVERRUN_COUNT, m_ovr);
    check("error", ERROR, m_err);
    if (SEND_PACKET === 1'b1) begin
      tx_send = cyc; tx_d = pk_d; tx_L = pk_L;
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic run_until_send(input int limit);
    int k = 0;
    do begin
      step();
      k++;
    end while (SEND_PACKET !== 1'b1 && k < limit);
    check("send_wait", SEND_PACKET, 1);
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int n_send, k, c0;
    RESET_N = 1'b0; ENABLE = 1'b0; SW_COMMAND = 4'd0; BUS_COMMAND = 4'd0;
    BUS_WE = 1'b0; TX_IDLE = 1'b1;
    cyc = 0;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    RESET_N = 1'b1;
    check("rst_command", COMMAND, 0);
    check("rst_send", SEND_PACKET, 0);
    check("rst_busy", BUSY, 0);
    check("rst_pkt", PACKET_COUNT, 0);
    check("rst_ovr", OVERRUN_COUNT, 0);
    check("rst_error", ERROR, 0);

    // Periodic switch packets.
    ENABLE = 1'b1; SW_COMMAND = 4'b1010; md_d = 2; md_L = 50;
    run(310);
    check("pkt_after_3", PACKET_COUNT, 3);
    check("sw_cmd", COMMAND, 4'b1010);
    check("sw_src", SOURCE, 0);

    // Bus hold for three ticks, then switches again.
    SW_COMMAND = 4'b1000;
    run(30);
    BUS_COMMAND = 4'b0001; BUS_WE = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      run_until_send(200);
      check("hold_cmd", COMMAND, 4'b0001);
      check("hold_src", SOURCE, 1);
    end
    run_until_send(200);
    check("after_hold_cmd", COMMAND, 4'b1000);
    check("after_hold_src", SOURCE, 0);

    // Bus write landing on the tick cycle is bypassed into that packet.
    k = 0;
    while ((cyc - en_start) % P != P - 1 && k < 2 * P) begin
      step();
      k++;
    end
    BUS_COMMAND = 4'b0110; BUS_WE = 1'b1;
    step();
    check("bypass_send", SEND_PACKET, 1);
    check("bypass_cmd", COMMAND, 4'b0110);
    check("bypass_src", SOURCE, 1);

    // Long packet drops two ticks; then a very long one saturates the overrun count.
    md_d = 2; md_L = 250;
    run_until_send(200);
    run(300);
    check("ovr_two", OVERRUN_COUNT, 2);
    md_L = 31000;
    run_until_send(400);
    run(30500);
    check("ovr_sat", OVERRUN_COUNT, 255);

    // Transmitter never starts: timeout sets sticky ERROR after 16 cycles.
    md_d = -1;
    run_until_send(1000);
    run(15);
    check("err_pre", ERROR, 0);
    step();
    check("err_set", ERROR, 1);
    check("err_idle", BUSY, 0);
    md_d = 2; md_L = 50;
    run_until_send(200);
    check("err_sticky", ERROR, 1);

    // Asynchronous reset in the middle of a packet.
    md_d = 3; md_L = 60;
    run_until_send(200);
    run(10);
    #3;
    RESET_N = 1'b0;
    #1;
    check("arst_command", COMMAND, 0);
    check("arst_busy", BUSY, 0);
    check("arst_source", SOURCE, 0);
    check("arst_pkt", PACKET_COUNT, 0);
    check("arst_ovr", OVERRUN_COUNT, 0);
    check("arst_error", ERROR, 0);
    check("arst_send", SEND_PACKET, 0);
    #1;
    RESET_N = 1'b1;
    model_reset();
    c0 = cyc;
    run_until_send(150);
    check("arst_latency", cyc - c0, 100);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      SW_COMMAND = 4'($urandom);
      if ($urandom_range(0, 149) == 0) begin
        BUS_WE = 1'b1;
        BUS_COMMAND = 4'($urandom);
      end
      if ($urandom_range(0, 399) == 0) ENABLE = ~ENABLE;
      if ($urandom_range(0, 299) == 0) begin
        md_d = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(1, 15));
        md_L = $urandom_range(1, 250);
      end
      step();
    end

    // ENABLE drops mid-packet, then packet counter wrap.
    ENABLE = 1'b1; md_d = 2; md_L = 50;
    run_until_send(300);
    run(10);
    ENABLE = 1'b0;
    n_send = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (SEND_PACKET === 1'b1) n_send++;
    end
    check("dis_no_send", n_send, 0);
    check("dis_busy", BUSY, 0);
    ENABLE = 1'b1;
    k = 0;
    while (m_pkt != 255 && k < 30000) begin
      step();
      k++;
    end
    check("pkt_255", PACKET_COUNT, 255);
    run_until_send(200);
    check("pkt_wrap", PACKET_COUNT, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
